// File: rtl/bp_lce_resp_arb_pkg.sv
// Shared types and helpers for the LCE response arbiter.
package bp_lce_resp_arb_pkg;

  typedef enum logic {
    e_arb_fixed = 1'b0,
    e_arb_rr    = 1'b1
  } bp_lce_resp_arb_mode_e;

  // Width helper that never returns 0, so single-value fields still get one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_lce_resp_arb_if.sv
// N-source response bundle: packed source payloads in, one registered response out.
interface bp_lce_resp_arb_if import bp_lce_resp_arb_pkg::*; #(
  parameter int num_src_p = 2,
  parameter int width_p   = 64
) ();
  localparam int id_w_lp = safe_clog2(num_src_p);

  logic [num_src_p*width_p-1:0] src_data_i;
  logic [num_src_p-1:0]         src_v_i;
  logic [num_src_p-1:0]         src_ready_o;
  logic [width_p-1:0]           resp_o;
  logic                         resp_v_o;
  logic                         resp_ready_i;
  logic [id_w_lp-1:0]           grant_id_o;

  modport master (
    output src_data_i, src_v_i, resp_ready_i,
    input  src_ready_o, resp_o, resp_v_o, grant_id_o
  );

  modport slave (
    input  src_data_i, src_v_i, resp_ready_i,
    output src_ready_o, resp_o, resp_v_o, grant_id_o
  );
endinterface

// File: rtl/bp_lce_resp_arb_fifo.sv
// Per-source skid FIFO, 1R1W; data visible the cycle after enqueue.
// ready_o is registered from the next count, so a full FIFO stays not-ready even while draining.
module bp_lce_resp_arb_fifo import bp_lce_resp_arb_pkg::*; #(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam int cnt_w_lp = safe_clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(els_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rptr, r_wptr;
  logic [cnt_w_lp-1:0] r_cnt, w_cnt_nxt;
  logic                r_ready;
  logic                w_enq, w_deq;

  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  assign w_enq = v_i & r_ready;
  assign w_deq = yumi_i & v_o;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_enq & ~w_deq)      w_cnt_nxt = r_cnt + 1'b1;
    else if (~w_enq & w_deq) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != els_lp);
      if (w_enq) r_wptr <= bump(r_wptr);
      if (w_deq) r_rptr <= bump(r_rptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

  assign ready_o = r_ready;
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
endmodule

// File: rtl/bp_lce_resp_arb.sv
// Buffered N-source LCE response arbiter (fixed+starvation guard or round-robin), registered output.
// Enqueue-to-output is 2 cycles; a stalled output holds its beat and stops all dequeues.
module bp_lce_resp_arb import bp_lce_resp_arb_pkg::*; #(
  parameter int                    num_src_p    = 2,
  parameter int                    width_p      = 64,
  parameter int                    els_p        = 2,
  parameter bp_lce_resp_arb_mode_e rr_mode_p    = e_arb_fixed,
  parameter int                    starve_lim_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bp_lce_resp_arb_if.slave   io
);
  localparam int id_w_lp   = safe_clog2(num_src_p);
  localparam int wait_w_lp = safe_clog2(starve_lim_p + 1);
  localparam logic [wait_w_lp-1:0] lim_lp      = wait_w_lp'(starve_lim_p);
  localparam logic [id_w_lp-1:0]   last_rst_lp = id_w_lp'(num_src_p - 1);

  logic [num_src_p-1:0] w_cand, w_ready;
  logic [width_p-1:0]   w_fifo_data [num_src_p];
  logic                 w_load, w_gnt_v, w_gnt;
  logic [id_w_lp-1:0]   w_gnt_id;

  logic [wait_w_lp-1:0] r_wait [num_src_p];
  logic [id_w_lp-1:0]   r_last, r_gid;
  logic                 r_resp_v;
  logic [width_p-1:0]   r_resp;

  for (genvar k = 0; k < num_src_p; k++) begin : g_src
    bp_lce_resp_arb_fifo #(.width_p(width_p), .els_p(els_p)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (io.src_data_i[k*width_p +: width_p]),
      .v_i     (io.src_v_i[k]),
      .ready_o (w_ready[k]),
      .v_o     (w_cand[k]),
      .data_o  (w_fifo_data[k]),
      .yumi_i  (w_gnt & (w_gnt_id == id_w_lp'(k)))
    );
  end

  assign w_load = ~r_resp_v | io.resp_ready_i;
  assign w_gnt  = w_gnt_v & w_load;

  // Descending loops: the last hit written is the highest-priority one.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    if (rr_mode_p == e_arb_rr) begin
      for (int i = num_src_p; i >= 1; i--) begin
        if (w_cand[id_w_lp'((int'(r_last) + i) % num_src_p)]) begin
          w_gnt_v  = 1'b1;
          w_gnt_id = id_w_lp'((int'(r_last) + i) % num_src_p);
        end
      end
    end else begin
      for (int k = num_src_p - 1; k >= 0; k--) begin
        if (w_cand[k]) begin
          w_gnt_v  = 1'b1;
          w_gnt_id = id_w_lp'(k);
        end
      end
      if (starve_lim_p != 0) begin
        for (int k = num_src_p - 1; k >= 0; k--) begin
          if (w_cand[k] && r_wait[k] == lim_lp) w_gnt_id = id_w_lp'(k);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < num_src_p; k++) r_wait[k] <= '0;
    end else begin
      for (int k = 0; k < num_src_p; k++) begin
        if (w_gnt && w_gnt_id == id_w_lp'(k))        r_wait[k] <= '0;
        else if (w_cand[k] && r_wait[k] != lim_lp)  r_wait[k] <= r_wait[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_resp_v <= 1'b0;
      r_resp   <= '0;
      r_gid    <= '0;
      r_last   <= last_rst_lp;
    end else if (w_load) begin
      r_resp_v <= w_gnt_v;
      if (w_gnt_v) begin
        r_resp <= w_fifo_data[w_gnt_id];
        r_gid  <= w_gnt_id;
        r_last <= w_gnt_id;
      end
    end
  end

  assign io.src_ready_o = w_ready;
  assign io.resp_o      = r_resp;
  assign io.resp_v_o    = r_resp_v;
  assign io.grant_id_o  = r_gid;
endmodule

// File: tb/tb_bp_lce_resp_arb.sv
// Three arbiter configurations on one clock, checked against a queue-level model plus directed literals.
module tb_bp_lce_resp_arb;
  import bp_lce_resp_arb_pkg::*;

  localparam int W   = 8;
  localparam int ELS = 2;
  localparam int NS  [3] = '{2, 4, 2};
  localparam int RR  [3] = '{0, 1, 0};
  localparam int LIM [3] = '{4, 8, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_lce_resp_arb_if #(.num_src_p(2), .width_p(W)) ifa ();
  bp_lce_resp_arb_if #(.num_src_p(4), .width_p(W)) ifb ();
  bp_lce_resp_arb_if #(.num_src_p(2), .width_p(W)) ifc ();

  bp_lce_resp_arb #(.num_src_p(2), .width_p(W), .els_p(ELS), .rr_mode_p(e_arb_fixed), .starve_lim_p(4))
    u_a (.clk_i(clk), .reset_i(rst_n), .io(ifa));
  bp_lce_resp_arb #(.num_src_p(4), .width_p(W), .els_p(ELS), .rr_mode_p(e_arb_rr), .starve_lim_p(8))
    u_b (.clk_i(clk), .reset_i(rst_n), .io(ifb));
  bp_lce_resp_arb #(.num_src_p(2), .width_p(W), .els_p(ELS), .rr_mode_p(e_arb_fixed), .starve_lim_p(0))
    u_c (.clk_i(clk), .reset_i(rst_n), .io(ifc));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: per-source queues of beats, output register, wait counts, last grant.
  int  mq     [3][4][$];
  bit  m_rdy  [3][4];
  int  m_wait [3][4];
  bit  m_v    [3];
  int  m_dat  [3];
  int  m_gid  [3];
  int  m_last [3];
  bit  m_live [3];
  bit  iv     [3][4];
  int  idat   [3][4];
  bit  irdy   [3];

  task automatic model_step(input int d);
    int  n, w;
    bit  load;
    n = NS[d];
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mq[d][k].delete();
        m_rdy[d][k]  = 1'b0;
        m_wait[d][k] = 0;
      end
      m_v[d] = 1'b0; m_dat[d] = 0; m_gid[d] = 0; m_last[d] = n - 1; m_live[d] = 1'b1;
      return;
    end
    load = !m_v[d] || irdy[d];
    w = -1;
    if (load) begin
      if (RR[d] != 0) begin
        for (int i = 1; i <= n; i++) begin
          int j = (m_last[d] + i) % n;
          if (w < 0 && mq[d][j].size() > 0) w = j;
        end
      end else begin
        for (int k = 0; k < n; k++)
          if (w < 0 && LIM[d] > 0 && m_wait[d][k] == LIM[d]) w = k;
        for (int k = 0; k < n; k++)
          if (w < 0 && mq[d][k].size() > 0) w = k;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (k == w) m_wait[d][k] = 0;
      else if (mq[d][k].size() > 0 && m_wait[d][k] < LIM[d]) m_wait[d][k]++;
    end
    if (load) begin
      m_v[d] = (w >= 0);
      if (w >= 0) begin
        m_dat[d] = mq[d][w].pop_front();
        m_gid[d] = w;
        m_last[d] = w;
      end
    end
    for (int k = 0; k < n; k++)
      if (iv[d][k] && m_rdy[d][k]) mq[d][k].push_back(idat[d][k]);
    for (int k = 0; k < n; k++)
      m_rdy[d][k] = (mq[d][k].size() < ELS);
  endtask

  function automatic int rdy_vec(input int d);
    int r = 0;
    for (int k = 0; k < NS[d]; k++) if (m_rdy[d][k]) r |= (1 << k);
    return r;
  endfunction

  task automatic cmp(input string nm, input int d, input int rdy, input int v, input int dat, input int gid);
    chk({nm, ".ready"}, rdy, rdy_vec(d));
    chk({nm, ".valid"}, v, int'(m_v[d]));
    if (m_v[d]) begin
      chk({nm, ".data"}, dat, m_dat[d]);
      chk({nm, ".grant"}, gid, m_gid[d]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    irdy[0] = ifa.resp_ready_i; irdy[1] = ifb.resp_ready_i; irdy[2] = ifc.resp_ready_i;
    for (int k = 0; k < 2; k++) begin
      iv[0][k] = ifa.src_v_i[k]; idat[0][k] = int'(ifa.src_data_i[k*W +: W]);
      iv[2][k] = ifc.src_v_i[k]; idat[2][k] = int'(ifc.src_data_i[k*W +: W]);
    end
    for (int k = 0; k < 4; k++) begin
      iv[1][k] = ifb.src_v_i[k]; idat[1][k] = int'(ifb.src_data_i[k*W +: W]);
    end
    for (int d = 0; d < 3; d++) model_step(d);
  end

  initial forever begin
    @(negedge clk);
    if (m_live[0]) cmp("mdlA", 0, int'(ifa.src_ready_o), int'(ifa.resp_v_o), int'(ifa.resp_o), int'(ifa.grant_id_o));
    if (m_live[1]) cmp("mdlB", 1, int'(ifb.src_ready_o), int'(ifb.resp_v_o), int'(ifb.resp_o), int'(ifb.grant_id_o));
    if (m_live[2]) cmp("mdlC", 2, int'(ifc.src_ready_o), int'(ifc.resp_v_o), int'(ifc.resp_o), int'(ifc.grant_id_o));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    ifa.src_v_i = '0; ifb.src_v_i = '0; ifc.src_v_i = '0;
  endtask

  initial begin
    int ga[$], gb[$], gc[$], outs[$];
    int nacc, drop_at, nv, waited;
    logic [7:0] b;
    bit acc;

    ifa.src_data_i = '0; ifb.src_data_i = '0; ifc.src_data_i = '0;
    ifa.resp_ready_i = 1'b1; ifb.resp_ready_i = 1'b1; ifc.resp_ready_i = 1'b1;

    // Reset held with all sources valid.
    rst_n = 1'b0;
    ifa.src_v_i = '1; ifb.src_v_i = '1; ifc.src_v_i = '1;
    repeat (3) begin
      tick();
      chk("rst.valid", int'(ifa.resp_v_o), 0);
      chk("rst.ready", int'(ifa.src_ready_o), 0);
      chk("rst.data", int'(ifa.resp_o), 0);
      chk("rst.grant", int'(ifa.grant_id_o), 0);
    end
    rst_n = 1'b1;
    all_idle();
    tick();
    chk("rel.readyA", int'(ifa.src_ready_o), 3);
    chk("rel.readyB", int'(ifb.src_ready_o), 15);

    // Single beat on source 1: visible two edges after enqueue, for one cycle.
    ifa.src_data_i = {8'hA5, 8'h00};
    ifa.src_v_i = 2'b10;
    tick();
    ifa.src_v_i = '0;
    chk("lat.t1.valid", int'(ifa.resp_v_o), 0);
    tick();
    chk("lat.t2.valid", int'(ifa.resp_v_o), 1);
    chk("lat.t2.data", int'(ifa.resp_o), 'hA5);
    chk("lat.t2.grant", int'(ifa.grant_id_o), 1);
    tick();
    chk("lat.t3.valid", int'(ifa.resp_v_o), 0);

    // All sources continuously valid on all three instances.
    ifa.src_v_i = 2'b11; ifb.src_v_i = 4'hF; ifc.src_v_i = 2'b11;
    for (int cyc = 0; cyc < 14; cyc++) begin
      ifa.src_data_i = {8'(128 + cyc), 8'(cyc)};
      ifc.src_data_i = {8'(128 + cyc), 8'(cyc)};
      for (int k = 0; k < 4; k++) ifb.src_data_i[k*W +: W] = 8'(k * 64 + cyc);
      tick();
      if (ifa.resp_v_o) ga.push_back(int'(ifa.grant_id_o));
      if (ifb.resp_v_o) gb.push_back(int'(ifb.grant_id_o));
      if (ifc.resp_v_o) gc.push_back(int'(ifc.grant_id_o));
    end
    chk("seq.countA", int'(ga.size() >= 10), 1);
    chk("seq.countB", int'(gb.size() >= 10), 1);
    chk("seq.countC", int'(gc.size() >= 10), 1);
    for (int i = 0; i < 10; i++) begin
      if (i < ga.size()) chk($sformatf("starve4.grant%0d", i), ga[i], (i % 5 == 4) ? 1 : 0);
      if (i < gb.size()) chk($sformatf("rr4.grant%0d", i), gb[i], i % 4);
      if (i < gc.size()) chk($sformatf("starve0.grant%0d", i), gc[i], 0);
    end

    // Round-robin with only sources 1 and 3 active, from a fresh reset.
    all_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    gb.delete();
    ifb.src_v_i = 4'b1010;
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int k = 0; k < 4; k++) ifb.src_data_i[k*W +: W] = 8'(k * 64 + cyc);
      tick();
      if (ifb.resp_v_o) gb.push_back(int'(ifb.grant_id_o));
    end
    chk("rr13.count", int'(gb.size() >= 6), 1);
    for (int i = 0; i < 6; i++)
      if (i < gb.size()) chk($sformatf("rr13.grant%0d", i), gb[i], (i % 2 == 0) ? 1 : 3);
    ifb.src_v_i = '0;
    repeat (4) tick();

    // Backpressure: output stalled, source 0 streaming.
    ifa.resp_ready_i = 1'b0;
    ifa.src_v_i = 2'b01;
    nacc = 0; drop_at = -1; b = 8'h10;
    for (int cyc = 0; cyc < 10; cyc++) begin
      ifa.src_data_i = {8'h00, b};
      acc = ifa.src_ready_o[0];
      tick();
      if (acc) begin nacc++; b++; end
      if (!ifa.src_ready_o[0] && drop_at < 0) drop_at = nacc;
      if (cyc >= 1) begin
        chk("bp.hold.valid", int'(ifa.resp_v_o), 1);
        chk("bp.hold.data", int'(ifa.resp_o), 'h10);
        chk("bp.hold.grant", int'(ifa.grant_id_o), 0);
      end
    end
    chk("bp.accepted", nacc, 3);
    chk("bp.ready_drop_after", drop_at, 3);
    ifa.src_v_i = '0;
    ifa.resp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (ifa.resp_v_o) outs.push_back(int'(ifa.resp_o));
      tick();
    end
    chk("bp.drain.count", outs.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < outs.size()) chk($sformatf("bp.drain%0d", i), outs[i], 'h10 + i);

    // Reset while beats are buffered and one is held at the output.
    ifa.resp_ready_i = 1'b0;
    ifa.src_v_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      ifa.src_data_i = {8'h00, 8'(8'h71 + i)};
      tick();
    end
    ifa.src_v_i = '0;
    ifa.resp_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst6.valid", int'(ifa.resp_v_o), 0);
    rst_n = 1'b1;
    nv = 0;
    repeat (4) begin
      tick();
      if (ifa.resp_v_o) nv++;
    end
    chk("rst6.quiet", nv, 0);
    ifa.src_data_i = {8'h00, 8'h5A};
    ifa.src_v_i = 2'b01;
    tick();
    ifa.src_v_i = '0;
    waited = 0;
    while (!ifa.resp_v_o && waited < 8) begin
      tick();
      waited++;
    end
    chk("rst6.seen", int'(ifa.resp_v_o), 1);
    chk("rst6.latency", waited, 1);
    chk("rst6.first", int'(ifa.resp_o), 'h5A);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_lce_resp_arb.md
# bp_lce_resp_arb

Parametrised, buffered N-source arbiter for LCE response traffic. It merges `num_src_p` ready/valid response sources into one LCE→CCE response channel. Each source gets its own skid FIFO. Arbitration is selectable as fixed priority with a starvation guard, or round-robin. The output stage is registered. It sits between LCE sub-engines (request, command, and future writeback/snoop engines) and the `lce_resp` network port, and supersedes combinational fixed-priority response muxing in LCE tops.

## Interface
Parameters:
- `num_src_p`, 2, number of response sources (≥1).
- `width_p`, 64, payload width in bits; set to `lce_cce_resp_width_lp` by the instantiating LCE.
- `els_p`, 2, entries per source FIFO (≥2).
- `rr_mode_p`, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `starve_lim_p`, 8, fixed-mode starvation limit in cycles; 0 disables the guard. Ignored when `rr_mode_p`=1.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: reset; **synchronous, active-low**.
- `src_data_i` in `num_src_p*width_p`: packed payloads; source k occupies bits [k*width_p +: width_p].
- `src_v_i` in `num_src_p`: per-source valid.
- `src_ready_o` out `num_src_p`: per-source ready; FIFO k not full.
- `resp_o` out `width_p`: registered output payload.
- `resp_v_o` out 1: output valid.
- `resp_ready_i` in 1: downstream ready.
- `grant_id_o` out `BSG_SAFE_CLOG2(num_src_p)`: source index of the payload currently on `resp_o`.

## Operation
- **Enqueue:** source k enqueues when `src_v_i[k] & src_ready_o[k]`. Data is stored in FIFO k in arrival order. Source order is preserved; cross-source order is not.
- **Candidates:** FIFO k is a candidate when it is non-empty.
- **Load condition:** the output register loads when `~resp_v_o | resp_ready_i`. The granted FIFO dequeues in the same cycle.
- **Fixed mode:**
  - Each source has a wait counter that increments, saturating at `starve_lim_p`, on every cycle the source is a candidate and is not granted. It clears on grant.
  - If any counter equals `starve_lim_p`, the lowest-index starved source wins.
  - Otherwise the lowest-index candidate wins.
- **Round-robin mode:**
  - Register `last_q` holds the last granted index.
  - The search starts at `last_q+1` and wraps modulo `num_src_p`.
  - `last_q` updates only on a grant. Its reset value is `num_src_p-1`, so source 0 is first.
- **No load:** if no candidate exists at a load opportunity, `resp_v_o` goes low on the next edge (provided the current beat was accepted).
- **Counter widths:** FIFO count is `BSG_SAFE_CLOG2(els_p+1)` bits. The wait counter is `BSG_SAFE_CLOG2(starve_lim_p+1)` bits and saturates (never wraps).

## Timing
- **Reset** (`reset_i`=0 at a clock edge):
  - All FIFOs empty; `src_ready_o`=0 while reset is asserted.
  - `resp_v_o`=0, `resp_o`=0, `grant_id_o`=0.
  - Wait counters 0; `last_q`=`num_src_p-1`.
  - A reset asserted mid-transfer discards all buffered and in-flight beats with no partial output.
- **Ready after reset:** `src_ready_o` goes to all 1s on the first cycle after reset deasserts.
- **Latency:** a beat enqueued in cycle t into an empty FIFO with an idle output appears with `resp_v_o`=1 in cycle t+2. There is no combinational path from `src_*` to `resp_*`.
- **Throughput:** one beat per cycle sustained when `resp_ready_i`=1.
- **Output stability:** while `resp_v_o & ~resp_ready_i`, `resp_o` and `grant_id_o` hold stable and no FIFO dequeues.
- **Full FIFO:** `src_ready_o[k]` is derived from the registered count, with no enqueue/dequeue bypass. When FIFO k is full, `src_ready_o[k]`=0 even in a cycle where k is being dequeued. It rises the following cycle.
- **Enqueue and dequeue together** on a non-full FIFO: the count is unchanged.
- **Single-entry source:** a beat enqueued in cycle t is not eligible for arbitration until t+1.

## Structure
- **Shared package:** add `bp_lce_resp_arb_mode_e` {`e_arb_fixed`=0, `e_arb_rr`=1} to `bp_common_pkg`. `rr_mode_p` is typed by this enum at integration.
- **Sub-module:** `bp_lce_resp_arb_fifo`, a one-read/one-write small FIFO (`width_p`, `els_p`) with `v_o`, `data_o`, `yumi_i`, and a registered `ready_o`, instantiated `num_src_p` times.
- **Top level:** arbitration, wait counters, `last_q`, and the output register live in the top module.

## Test plan
1. **Reset:** hold `reset_i`=0 for 3 cycles with `src_v_i`=all 1s → `resp_v_o`=0 and `src_ready_o`=0 throughout. After release, `src_ready_o`=11 (`num_src_p`=2).
2. **Latency:** single beat 0xA5 on source 1 at cycle t, `resp_ready_i`=1 → `resp_v_o`=1, `resp_o`=0xA5, `grant_id_o`=1 at t+2, for exactly 1 cycle.
3. **Fixed-mode starvation:** `rr_mode_p`=0, `starve_lim_p`=4, both sources continuously valid, `resp_ready_i`=1 → grant sequence 0,0,0,0,1 repeating. With `starve_lim_p`=0 → source 0 only.
4. **Round-robin:** `rr_mode_p`=1, `num_src_p`=4, all sources valid → `grant_id_o` sequence 0,1,2,3,0. With only sources 1 and 3 valid → 1,3,1,3.
5. **Backpressure:** `resp_ready_i`=0 for 10 cycles, `els_p`=2, source 0 sending → `resp_o` stable, and `src_ready_o[0]` drops after the 3rd accepted beat (2 in FIFO + 1 in output register). Releasing → 3 beats in original order.
6. **Reset mid-stream:** reset asserted while 2 beats are buffered → no beat is emitted after reset, and the first post-reset beat is the newly sent 0x5A.
